// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, constants and sizing helper for hazard_unit_ext
package hazard_pkg;

    // RUN: normal issue; LOAD_WAIT: extra load-use bubbles still owed.
    typedef enum logic {
        RUN       = 1'b0,
        LOAD_WAIT = 1'b1
    } hz_state_e;

    // Register $zero never carries a real dependency.
    localparam int REG_ZERO = 0;

    // Width of the LOAD_WAIT down-counter; kept at least 1 bit so the
    // register stays legal when only a single bubble is configured.
    function automatic int wait_cnt_w(input int stalls);
        return (stalls > 1) ? $clog2(stalls) : 1;
    endfunction

endpackage

// File: rtl/hazard_unit_ext_if.sv
// rtl/hazard_unit_ext_if.sv - pipeline <-> hazard unit signal bundle
// master: pipeline side (drives IF/ID, ID/EX and mult/div status, receives controls)
// slave : hazard unit side (receives status, drives hold/bubble/flush/branch controls)
interface hazard_unit_ext_if #(
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] rs_if_id;
    logic [REG_ADDR_W-1:0] rt_if_id;
    logic                  uses_rs_if_id;
    logic                  uses_rt_if_id;
    logic [REG_ADDR_W-1:0] rt_id_ex;
    logic                  mem_read_id_ex;
    logic                  beq_id_ex;
    logic                  bne_id_ex;
    logic                  cmp_equal;
    logic [DATA_W-1:0]     offset_id_ex;
    logic                  is_jump;
    logic                  md_start;
    logic                  md_done;
    logic                  md_use_if_id;
    logic                  hold_pc;
    logic                  hold_if_id;
    logic                  bubble_id_ex;
    logic                  flush_if_id;
    logic                  take_branch;
    logic [DATA_W-1:0]     pc_offset;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output rs_if_id, rt_if_id, uses_rs_if_id, uses_rt_if_id, rt_id_ex,
               mem_read_id_ex, beq_id_ex, bne_id_ex, cmp_equal, offset_id_ex,
               is_jump, md_start, md_done, md_use_if_id,
        input  hold_pc, hold_if_id, bubble_id_ex, flush_if_id, take_branch,
               pc_offset, stall_cnt
    );

    modport slave (
        input  rs_if_id, rt_if_id, uses_rs_if_id, uses_rt_if_id, rt_id_ex,
               mem_read_id_ex, beq_id_ex, bne_id_ex, cmp_equal, offset_id_ex,
               is_jump, md_start, md_done, md_use_if_id,
        output hold_pc, hold_if_id, bubble_id_ex, flush_if_id, take_branch,
               pc_offset, stall_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - W-bit up-counter that sticks at all-ones
// ports: clk, rst (sync active-low), inc (count enable), count (current value)
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/hazard_unit_ext.sv
// rtl/hazard_unit_ext.sv - load-use / branch / jump / mult-div hazard control beside ID
// ports: clk, rst (sync active-low), hif (slave side of hazard_unit_ext_if):
//   in : IF/ID operands and use flags, ID/EX load/branch info, jump, mult/div status
//   out: hold_pc, hold_if_id, bubble_id_ex, flush_if_id, take_branch (combinational),
//        pc_offset (registered), stall_cnt (saturating stall-cycle count)
module hazard_unit_ext
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W      = 5,
    parameter int DATA_W          = 32,
    parameter int LOAD_USE_STALLS = 1,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst,
    hazard_unit_ext_if.slave  hif
);
    localparam int WW = wait_cnt_w(LOAD_USE_STALLS);
    localparam logic [WW-1:0] WAIT_INIT = WW'(LOAD_USE_STALLS - 2);

    hz_state_e      state, state_nxt;
    logic [WW-1:0]  wait_cnt, wait_nxt;
    logic           md_busy;
    logic           br_taken, lu_hit, md_hit;

    assign br_taken = (hif.beq_id_ex & hif.cmp_equal) | (hif.bne_id_ex & ~hif.cmp_equal);
    assign lu_hit   = hif.mem_read_id_ex
                    & (hif.rt_id_ex != REG_ADDR_W'(REG_ZERO))
                    & ((hif.uses_rs_if_id & (hif.rs_if_id == hif.rt_id_ex))
                     | (hif.uses_rt_if_id & (hif.rt_if_id == hif.rt_id_ex)));
    // A result arriving this cycle satisfies the HI/LO reader without a stall.
    assign md_hit   = md_busy & ~hif.md_done & hif.md_use_if_id;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        wait_nxt         = wait_cnt;
        hif.hold_pc      = 1'b0;
        hif.hold_if_id   = 1'b0;
        hif.bubble_id_ex = 1'b0;
        hif.flush_if_id  = 1'b0;
        hif.take_branch  = 1'b0;
        if (rst) begin
            unique case (state)
                RUN: begin
                    if (br_taken) begin
                        // IF/ID holds a wrong-path instruction, so its hazards are moot.
                        hif.take_branch  = 1'b1;
                        hif.flush_if_id  = 1'b1;
                        hif.bubble_id_ex = 1'b1;
                    end else if (lu_hit) begin
                        hif.hold_pc      = 1'b1;
                        hif.hold_if_id   = 1'b1;
                        hif.bubble_id_ex = 1'b1;
                        if (LOAD_USE_STALLS > 1) begin
                            state_nxt = LOAD_WAIT;
                            wait_nxt  = WAIT_INIT;
                        end
                    end else if (md_hit) begin
                        hif.hold_pc      = 1'b1;
                        hif.hold_if_id   = 1'b1;
                        hif.bubble_id_ex = 1'b1;
                    end else if (hif.is_jump) begin
                        // Only flushed once the jump is no longer being held.
                        hif.flush_if_id = 1'b1;
                    end
                end
                LOAD_WAIT: begin
                    hif.hold_pc      = 1'b1;
                    hif.hold_if_id   = 1'b1;
                    hif.bubble_id_ex = 1'b1;
                    if (wait_cnt == '0) begin
                        state_nxt = RUN;
                    end else begin
                        wait_nxt = wait_cnt - 1'b1;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            md_busy       <= 1'b0;
            hif.pc_offset <= '0;
        end else begin
            if (hif.md_done) begin
                md_busy <= 1'b0;
            end else if (hif.md_start && !br_taken) begin
                md_busy <= 1'b1;
            end
            if (hif.take_branch) begin
                hif.pc_offset <= hif.offset_id_ex;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hif.hold_pc),
        .count (hif.stall_cnt)
    );
endmodule
